// File: rtl/hazard_stall_ctrl.sv
// Purpose: produces the stall/flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
// Latency: the control outputs are combinational (0 cycles); halted, mem_err and stall_cycles are registered.
// Backpressure: a multi-cycle memory access freezes the whole pipe, and a load-use hazard holds PC and IF/ID.
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   id_rs/id_rt       : source registers of the instruction in ID; id_uses_rt qualifies id_rt
//   ex_MemRead/ex_rd  : the EX instruction is a load, and its destination register
//   id_branch_taken   : a branch resolved in ID is taken
//   id_hlt            : HLT is decoded in ID
//   mem_req/mem_ready : MEM-stage access request and completion
//   *_stall/*_flush   : per-register hold and bubble controls
//   halted, mem_err   : drain state reached / sticky watchdog error
//   stall_cycles      : saturating count of stall cycles
module hazard_stall_ctrl #(
  parameter int REG_ID_W    = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_ID_W-1:0] id_rs,
  input  logic [REG_ID_W-1:0] id_rt,
  input  logic                id_uses_rt,
  input  logic                ex_MemRead,
  input  logic [REG_ID_W-1:0] ex_rd,
  input  logic                id_branch_taken,
  input  logic                id_hlt,
  input  logic                mem_req,
  input  logic                mem_ready,
  output logic                pc_stall,
  output logic                ifid_stall,
  output logic                ifid_flush,
  output logic                idex_stall,
  output logic                idex_flush,
  output logic                exmem_stall,
  output logic                memwb_flush,
  output logic                halted,
  output logic                mem_err,
  output logic [CNT_W-1:0]    stall_cycles
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_t;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_freeze;
  logic w_luse;

  assign w_freeze = mem_req & ~mem_ready;
  // Register 0 is hard-wired, so a load targeting it can never create a hazard.
  assign w_luse   = ex_MemRead & (ex_rd != '0) &
                    ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    memwb_flush = 1'b0;
    if (!rst) begin
      if (r_state == HALTED) begin
        // Keep feeding bubbles so the younger stages drain. MEM may still be
        // waiting on the last access, so the freeze is still honoured.
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
        if (w_freeze) begin
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_stall = 1'b1;
          memwb_flush = 1'b1;
        end
      end else if (w_freeze) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_flush = 1'b1;
      end else if (w_luse) begin
        // A branch that arrives together with a load-use hazard is dropped
        // here. ID holds the branch and resolves it again next cycle.
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end else begin
        if (id_branch_taken) begin
          ifid_flush = 1'b1;
        end
        if (id_hlt && (r_state == RUN)) begin
          pc_stall   = 1'b1;
          ifid_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if ((r_state != HALTED) && pc_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      case (r_state)
        RUN: begin
          if (w_freeze) begin
            if (MEM_TIMEOUT <= 1) begin
              r_mem_err <= 1'b1;
              r_state   <= HALTED;
            end else begin
              r_wait_cnt <= WAIT_W'(1);
              r_state    <= MEM_WAIT;
            end
          end else if (id_hlt && !w_luse) begin
            r_state <= HALTED;
          end
        end
        MEM_WAIT: begin
          if (w_freeze) begin
            // The counter holds the number of freeze cycles seen so far. This
            // edge makes MEM_TIMEOUT of them, so the watchdog trips here.
            if (r_wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
              r_mem_err  <= 1'b1;
              r_wait_cnt <= '0;
              r_state    <= HALTED;
            end else begin
              r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
          end else begin
            r_wait_cnt <= '0;
            r_state    <= RUN;
          end
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign halted       = (r_state == HALTED);
  assign mem_err      = r_mem_err;
  assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
  localparam int REG_ID_W    = 4;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 16;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic                clk;
  logic                rst;
  logic [REG_ID_W-1:0] id_rs, id_rt, ex_rd;
  logic                id_uses_rt, ex_MemRead, id_branch_taken, id_hlt, mem_req, mem_ready;
  logic                pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic                exmem_stall, memwb_flush, halted, mem_err;
  logic [CNT_W-1:0]    stall_cycles;

  int n_chk  = 0;
  int n_fail = 0;

  hazard_stall_ctrl #(.REG_ID_W(REG_ID_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_rd(ex_rd),
    .id_branch_taken(id_branch_taken), .id_hlt(id_hlt),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush),
    .exmem_stall(exmem_stall), .memwb_flush(memwb_flush),
    .halted(halted), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model tracks what the pipeline situation is: halted or not, how many
  // freeze cycles in a row have happened, the error flag and the stall count.
  logic m_valid = 1'b0;
  logic m_halt, m_err;
  int   m_wait;
  int   m_cnt;

  always @(negedge clk) begin
    automatic logic frz = mem_req && !mem_ready;
    automatic logic lu  = ex_MemRead && (ex_rd != 0) &&
                          ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    automatic logic e_pc = 0, e_ifs = 0, e_iff = 0, e_ixs = 0, e_ixf = 0, e_ems = 0, e_mwf = 0;
    if (!rst) begin
      if (m_halt) begin
        e_pc = 1; e_iff = 1;
        if (frz) begin e_ifs = 1; e_ixs = 1; e_ems = 1; e_mwf = 1; end
      end else if (frz) begin
        e_pc = 1; e_ifs = 1; e_ixs = 1; e_ems = 1; e_mwf = 1;
      end else if (lu) begin
        e_pc = 1; e_ifs = 1; e_ixf = 1;
      end else begin
        if (id_branch_taken) e_iff = 1;
        if (id_hlt && m_wait == 0) begin e_pc = 1; e_iff = 1; end
      end
    end
    if (m_valid) begin
      chk("model_ctrl",
          {25'd0, pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush},
          {25'd0, e_pc, e_ifs, e_iff, e_ixs, e_ixf, e_ems, e_mwf});
      chk("model_halted", {31'd0, halted}, {31'd0, m_halt});
      chk("model_mem_err", {31'd0, mem_err}, {31'd0, m_err});
      chk("model_stall_cycles", {16'd0, stall_cycles}, m_cnt);
    end
    // Advance the model across the coming rising edge (the inputs hold until then).
    if (rst) begin
      m_valid = 1; m_halt = 0; m_err = 0; m_wait = 0; m_cnt = 0;
    end else if (m_valid && !m_halt) begin
      if (e_pc && m_cnt < CNT_MAX) m_cnt++;
      if (frz) begin
        m_wait++;
        if (m_wait >= MEM_TIMEOUT) begin m_halt = 1; m_err = 1; m_wait = 0; end
      end else begin
        if (id_hlt && !lu && m_wait == 0) m_halt = 1;
        m_wait = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drv(input logic [3:0] rs, input logic [3:0] rt, input logic urt,
                     input logic mr, input logic [3:0] rd, input logic br,
                     input logic hlt, input logic mreq, input logic mrdy);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_MemRead = mr; ex_rd = rd;
    id_branch_taken = br; id_hlt = hlt; mem_req = mreq; mem_ready = mrdy;
  endtask

  task automatic idle();
    drv(4'd1, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected end before 5ms");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle();
    // During reset a pending memory access must not produce any control output.
    drv(4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    adv(); adv();
    settle();
    chk("rst_pc_stall", {31'd0, pc_stall}, 32'd0);
    chk("rst_exmem_stall", {31'd0, exmem_stall}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
    chk("rst_stall_cycles", {16'd0, stall_cycles}, 32'd0);
    adv();
    rst = 1'b0;

    // Load-use hazard on rs.
    drv(4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("luse_pc_stall", {31'd0, pc_stall}, 32'd1);
    chk("luse_ifid_stall", {31'd0, ifid_stall}, 32'd1);
    chk("luse_idex_flush", {31'd0, idex_flush}, 32'd1);
    chk("luse_ifid_flush", {31'd0, ifid_flush}, 32'd0);
    chk("luse_cnt_before", {16'd0, stall_cycles}, 32'd0);
    adv();
    idle();
    settle();
    chk("luse_cnt_after", {16'd0, stall_cycles}, 32'd1);
    adv();

    // Register 0 never causes a hazard.
    drv(4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("r0_no_stall", {31'd0, pc_stall}, 32'd0);
    adv();
    // An rt match only counts when rt is actually read.
    drv(4'd1, 4'd5, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("rt_unused_no_stall", {31'd0, pc_stall}, 32'd0);
    adv();
    drv(4'd1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("rt_used_stall", {31'd0, idex_flush}, 32'd1);
    adv();

    // A branch together with load-use produces only the load-use outputs; the next cycle, the branch flushes on its own.
    drv(4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    chk("br_luse_ifid_flush", {31'd0, ifid_flush}, 32'd0);
    chk("br_luse_idex_flush", {31'd0, idex_flush}, 32'd1);
    adv();
    drv(4'd3, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    chk("br_ifid_flush", {31'd0, ifid_flush}, 32'd1);
    chk("br_pc_stall", {31'd0, pc_stall}, 32'd0);
    chk("br_cnt", {16'd0, stall_cycles}, 32'd3);
    adv();

    // Three-cycle memory freeze, then completion.
    rst = 1'b1; idle(); adv(); rst = 1'b0;
    drv(4'd1, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) begin
      settle();
      chk("frz_exmem_stall", {31'd0, exmem_stall}, 32'd1);
      chk("frz_memwb_flush", {31'd0, memwb_flush}, 32'd1);
      chk("frz_ifid_flush", {31'd0, ifid_flush}, 32'd0);
      adv();
    end
    drv(4'd1, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    settle();
    chk("frz_done_exmem", {31'd0, exmem_stall}, 32'd0);
    chk("frz_done_pc", {31'd0, pc_stall}, 32'd0);
    adv();
    idle();
    settle();
    chk("frz_cnt", {16'd0, stall_cycles}, 32'd3);
    chk("frz_not_halted", {31'd0, halted}, 32'd0);
    adv();

    // Watchdog: the 15th consecutive freeze edge trips it.
    rst = 1'b1; idle(); adv(); rst = 1'b0;
    drv(4'd1, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (14) adv();
    settle();
    chk("wd_not_yet", {31'd0, mem_err}, 32'd0);
    adv();
    idle();
    settle();
    chk("wd_mem_err", {31'd0, mem_err}, 32'd1);
    chk("wd_halted", {31'd0, halted}, 32'd1);
    chk("wd_cnt", {16'd0, stall_cycles}, 32'd15);
    chk("wd_ifid_flush", {31'd0, ifid_flush}, 32'd1);
    repeat (5) adv();
    settle();
    chk("wd_err_sticky", {31'd0, mem_err}, 32'd1);
    rst = 1'b1;
    settle();
    chk("wd_rst_pc", {31'd0, pc_stall}, 32'd0);
    adv();
    rst = 1'b0;
    settle();
    chk("wd_rst_err", {31'd0, mem_err}, 32'd0);
    chk("wd_rst_halted", {31'd0, halted}, 32'd0);
    chk("wd_rst_cnt", {16'd0, stall_cycles}, 32'd0);
    adv();

    // HLT drain: one load-use stall, then HLT (which is also a counted stall).
    drv(4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    adv();
    drv(4'd1, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    chk("hlt_pc_stall", {31'd0, pc_stall}, 32'd1);
    chk("hlt_ifid_flush", {31'd0, ifid_flush}, 32'd1);
    chk("hlt_not_yet", {31'd0, halted}, 32'd0);
    adv();
    drv(4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("hlt_halted", {31'd0, halted}, 32'd1);
    chk("hlt_idex_flush", {31'd0, idex_flush}, 32'd0);
    chk("hlt_cnt", {16'd0, stall_cycles}, 32'd2);
    repeat (4) adv();
    settle();
    chk("hlt_cnt_frozen", {16'd0, stall_cycles}, 32'd2);
    chk("hlt_still_flush", {31'd0, ifid_flush}, 32'd1);
    adv();

    // Saturation of the stall counter.
    rst = 1'b1; idle(); adv(); rst = 1'b0;
    drv(4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (65540) adv();
    settle();
    chk("sat_cnt", {16'd0, stall_cycles}, 32'h0000_FFFF);
    adv();
    drv(4'd1, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    adv();
    idle();
    settle();
    chk("sat_halted", {31'd0, halted}, 32'd1);
    chk("sat_cnt_hold", {16'd0, stall_cycles}, 32'h0000_FFFF);
    adv();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
